sequence_player: RTL and testbench



---
 rtl/sequence_player.sv | 120 ++++++++++++
 tb/tb_sequence_player.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
// Plays the stored colour sequence oldest-first as timed on/off flashes.
// Optional `SEQUENCE_PLAYER_PAUSE_EN adds a pause input that freezes playback timing.
module sequence_player #(
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SEQUENCE_PLAYER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [5:0]       level,
    input  logic [32:0][1:0] segment,
    output logic [1:0]       colour_out,
    output logic             colour_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       level_clamped;
    logic             hold;

    assign level_clamped = (level > 6'd32) ? 6'd32 : level;

`ifdef SEQUENCE_PLAYER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = level_clamped;
                    if (level_clamped == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = level_clamped;
                        tmr_d   = '0;
                        state_d = S_ON;
                    end
                end
            end
            S_ON: begin
                if (!hold) begin
                    if (tmr_q == ON_LAST) begin
                        tmr_d   = '0;
                        state_d = S_OFF;
                    end else begin
                        tmr_d = tmr_q + TMR_ONE;
                    end
                end
            end
            S_OFF: begin
                if (!hold) begin
                    if (tmr_q == OFF_LAST) begin
                        tmr_d = '0;
                        // Slot 1 is the newest colour and therefore the last one shown.
                        if (idx_q == 6'd1) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q - 6'd1;
                            state_d = S_ON;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign colour_valid = (state_q == S_ON);
    assign colour_out   = colour_valid ? segment[idx_q] : 2'b00;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON_CYCLES=3, OFF_CYCLES=2.
module tb_sequence_player;

    localparam int ON_C  = 3;
    localparam int OFF_C = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic [5:0]       level = '0;
    logic [32:0][1:0] seg = '0;
    logic [1:0]       colour_out;
    logic             colour_valid;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] seq_exp [15] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                                 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};

    sequence_player #(
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef SEQUENCE_PLAYER_PAUSE_EN
        .pause       (pause),
`endif
        .level       (level),
        .segment     (seg),
        .colour_out  (colour_out),
        .colour_valid(colour_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Returns positioned 1ns into cycle 1 (start sampled at edge 0).
    task automatic start_play(input logic [5:0] lv);
        @(negedge clk);
        level = lv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_base_seg();
        seg = '0;
        seg[3] = 2'b10;
        seg[2] = 2'b01;
        seg[1] = 2'b11;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (colour_out !== 2'b00) begin n_fail++; $display("FAIL reset_colour_out got=%b exp=00", colour_out); end
        n_checks++;
        if (colour_valid !== 1'b0) begin n_fail++; $display("FAIL reset_colour_valid got=%b exp=0", colour_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_sequence();
        logic [1:0] ec;
        load_base_seg();
        start_play(6'd3);
        for (int c = 1; c <= 17; c++) begin
            ec = (c <= 15) ? seq_exp[c-1] : 2'b00;
            n_checks++;
            if (colour_out !== ec) begin n_fail++; $display("FAIL seq_colour c=%0d got=%b exp=%b", c, colour_out, ec); end
            n_checks++;
            if (colour_valid !== (ec != 2'b00)) begin n_fail++; $display("FAIL seq_valid c=%0d got=%b exp=%b", c, colour_valid, ec != 2'b00); end
            n_checks++;
            if (done !== (c == 16)) begin n_fail++; $display("FAIL seq_done c=%0d got=%b exp=%b", c, done, c == 16); end
            n_checks++;
            if (busy !== (c <= 16)) begin n_fail++; $display("FAIL seq_busy c=%0d got=%b exp=%b", c, busy, c <= 16); end
            next_cycle();
        end
    endtask

    task automatic test_empty();
        start_play(6'd0);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done c=1 got=%b exp=1", done); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy c=1 got=%b exp=1", busy); end
        n_checks++;
        if (colour_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid c=1 got=%b exp=0", colour_valid); end
        next_cycle();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL empty_done c=2 got=%b exp=0", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy c=2 got=%b exp=0", busy); end
        n_checks++;
        if (colour_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid c=2 got=%b exp=0", colour_valid); end
        next_cycle();
    endtask

    task automatic test_clamp();
        int dones = 0;
        int done_c = -1;
        seg = '0;
        for (int k = 1; k <= 32; k++) seg[k] = 2'(k);
        seg[32] = 2'b10;
        seg[31] = 2'b01;
        seg[1]  = 2'b11;
        start_play(6'd40);
        for (int c = 1; c <= 170; c++) begin
            if (c == 1) begin
                n_checks++;
                if (colour_out !== 2'b10) begin n_fail++; $display("FAIL clamp_first got=%b exp=10", colour_out); end
            end
            if (c == 6) begin
                n_checks++;
                if (colour_out !== 2'b01) begin n_fail++; $display("FAIL clamp_second got=%b exp=01", colour_out); end
            end
            if (c == 156) begin
                n_checks++;
                if (colour_out !== 2'b11) begin n_fail++; $display("FAIL clamp_last got=%b exp=11", colour_out); end
            end
            if (done === 1'b1) begin
                dones++;
                done_c = c;
            end
            next_cycle();
        end
        n_checks++;
        if (done_c != 1 + 32 * (ON_C + OFF_C)) begin n_fail++; $display("FAIL clamp_done_cycle got=%0d exp=%0d", done_c, 1 + 32 * (ON_C + OFF_C)); end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL clamp_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        int done_c = -1;
        seg = '0;
        seg[2] = 2'b01;
        seg[1] = 2'b10;
        start_play(6'd2);
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) start = 1'b0;
            if (c == 1) begin
                n_checks++;
                if (colour_out !== 2'b01) begin n_fail++; $display("FAIL ign_first got=%b exp=01", colour_out); end
            end
            if (c == 6) begin
                n_checks++;
                if (colour_out !== 2'b10) begin n_fail++; $display("FAIL ign_second got=%b exp=10", colour_out); end
            end
            if (done === 1'b1) begin
                dones++;
                done_c = c;
            end
            if (c == 4) begin
                level = 6'd5;
                start = 1'b1;
            end
            next_cycle();
        end
        n_checks++;
        if (done_c != 11) begin n_fail++; $display("FAIL ign_done_cycle got=%0d exp=11", done_c); end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_async_reset();
        load_base_seg();
        start_play(6'd3);
        next_cycle();
        n_checks++;
        if (colour_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b exp=1", colour_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (colour_out !== 2'b00) begin n_fail++; $display("FAIL rst_colour got=%b exp=00", colour_out); end
        n_checks++;
        if (colour_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", colour_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start_play(6'd1);
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) begin
                n_checks++;
                if (colour_out !== 2'b11) begin n_fail++; $display("FAIL rst_replay_colour got=%b exp=11", colour_out); end
            end
            n_checks++;
            if (done !== (c == 6)) begin n_fail++; $display("FAIL rst_replay_done c=%0d got=%b exp=%b", c, done, c == 6); end
            next_cycle();
        end
    endtask

`ifdef SEQUENCE_PLAYER_PAUSE_EN
    task automatic test_pause();
        logic [1:0] ec;
        load_base_seg();
        start_play(6'd3);
        for (int c = 1; c <= 21; c++) begin
            pause = (c >= 2 && c <= 5);
            if (c <= 7)       ec = 2'b10;
            else if (c <= 19) ec = seq_exp[c-5];
            else              ec = 2'b00;
            n_checks++;
            if (colour_out !== ec) begin n_fail++; $display("FAIL pause_colour c=%0d got=%b exp=%b", c, colour_out, ec); end
            n_checks++;
            if (done !== (c == 20)) begin n_fail++; $display("FAIL pause_done c=%0d got=%b exp=%b", c, done, c == 20); end
            next_cycle();
        end
        pause = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_empty();
        test_clamp();
        test_ignored_start();
        test_async_reset();
`ifdef SEQUENCE_PLAYER_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
